// File: rtl/noc_routing_pkg.sv
// Shared NoC routing definitions: port indices, selection modes and a width helper.
package noc_routing_pkg;

  localparam int LOCAL = 0;
  localparam int EAST  = 1;
  localparam int NORTH = 2;
  localparam int WEST  = 3;
  localparam int SOUTH = 4;

  localparam int SEL_CREDIT = 0;
  localparam int SEL_RR     = 1;

  // Address width for a mesh dimension; a 1- or 2-wide dimension still gets one bit.
  function automatic int log2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [4:0] port_onehot(input int idx);
    return 5'(1) << idx;
  endfunction

endpackage

// File: rtl/mesh_dir.sv
// Direction flags of a destination relative to this router in a 2D mesh.
module mesh_dir #(
  parameter int XW = 2,
  parameter int YW = 2
) (
  input  logic [XW-1:0] current_x,
  input  logic [YW-1:0] current_y,
  input  logic [XW-1:0] dest_x,
  input  logic [YW-1:0] dest_y,
  output logic          x_plus,
  output logic          x_min,
  output logic          y_plus,
  output logic          y_min
);

  // y grows southwards, so a smaller destination y means going NORTH.
  assign x_plus = dest_x > current_x;
  assign x_min  = dest_x < current_x;
  assign y_plus = dest_y > current_y;
  assign y_min  = dest_y < current_y;

endmodule

// File: rtl/duato_adaptive_port_sel.sv
// Duato-style adaptive output port selection with escape-VC fallback and stall re-route.
module duato_adaptive_port_sel
  import noc_routing_pkg::*;
#(
  parameter int NX        = 4,
  parameter int NY        = 4,
  parameter int CRDw      = 4,
  parameter int SEL_MODE  = 0,
  parameter int STALL_THR = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [log2(NX)-1:0]    current_x,
  input  logic [log2(NY)-1:0]    current_y,
  input  logic                   in_valid,
  input  logic [log2(NX)-1:0]    dest_x,
  input  logic [log2(NY)-1:0]    dest_y,
  output logic                   in_ready,
  input  logic [4*CRDw-1:0]      credit_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             out_port,
  output logic                   out_escape,
  output logic [3:0]             out_destport
);

  localparam int XW = log2(NX);
  localparam int YW = log2(NY);
  localparam int CW = $clog2(STALL_THR + 1);

  logic            x_plus, x_min, y_plus, y_min;
  logic            x_diff, y_diff;
  logic [4:0]      x_port, y_port;
  logic [CRDw-1:0] cred_e, cred_n, cred_w, cred_s;
  logic [CRDw-1:0] x_cred, y_cred;
  logic [4:0]      sel_port, sel_xy;
  logic            sel_escape, sel_flip;
  logic            accept;
  logic            toggle;
  logic [4:0]      xy_port;
  logic [CW-1:0]   stall_cnt;

  mesh_dir #(
    .XW(XW),
    .YW(YW)
  ) u_dir (
    .current_x(current_x),
    .current_y(current_y),
    .dest_x   (dest_x),
    .dest_y   (dest_y),
    .x_plus   (x_plus),
    .x_min    (x_min),
    .y_plus   (y_plus),
    .y_min    (y_min)
  );

  assign x_diff = x_plus | x_min;
  assign y_diff = y_plus | y_min;
  assign x_port = x_plus ? port_onehot(EAST) : port_onehot(WEST);
  assign y_port = y_plus ? port_onehot(SOUTH) : port_onehot(NORTH);

  assign cred_e = credit_in[0*CRDw +: CRDw];
  assign cred_n = credit_in[1*CRDw +: CRDw];
  assign cred_w = credit_in[2*CRDw +: CRDw];
  assign cred_s = credit_in[3*CRDw +: CRDw];
  assign x_cred = x_plus ? cred_e : cred_w;
  assign y_cred = y_plus ? cred_s : cred_n;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Candidate selection; the XY port is kept so a stalled result can fall back to it.
  always_comb begin
    sel_port   = port_onehot(LOCAL);
    sel_xy     = port_onehot(LOCAL);
    sel_escape = 1'b0;
    sel_flip   = 1'b0;
    if (x_diff)      sel_xy = x_port;
    else if (y_diff) sel_xy = y_port;

    if (x_diff && y_diff) begin
      if (x_cred == '0 && y_cred == '0) begin
        sel_port   = sel_xy;
        sel_escape = 1'b1;
      end else if (SEL_MODE == SEL_RR) begin
        sel_port = toggle ? y_port : x_port;
        sel_flip = 1'b1;
      end else if (x_cred > y_cred) begin
        sel_port = x_port;
      end else if (y_cred > x_cred) begin
        sel_port = y_port;
      end else begin
        sel_port = toggle ? y_port : x_port;
        sel_flip = 1'b1;
      end
    end else if (x_diff) begin
      sel_port   = x_port;
      sel_escape = (x_cred == '0);
    end else if (y_diff) begin
      sel_port   = y_port;
      sel_escape = (y_cred == '0);
    end
  end

  // Result register; a held adaptive result is forced onto the escape VC once it has stalled too long.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_port     <= '0;
      out_escape   <= 1'b0;
      out_destport <= '0;
      xy_port      <= '0;
      toggle       <= 1'b0;
      stall_cnt    <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_port     <= sel_port;
      out_escape   <= sel_escape;
      out_destport <= {x_plus, y_min, x_diff, y_diff};
      xy_port      <= sel_xy;
      stall_cnt    <= '0;
      if (sel_flip) toggle <= ~toggle;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      stall_cnt <= '0;
    end else if (out_valid && !out_escape) begin
      if (stall_cnt >= CW'(STALL_THR - 1)) begin
        out_port   <= xy_port;
        out_escape <= 1'b1;
        stall_cnt  <= '0;
      end else begin
        stall_cnt <= stall_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_duato_adaptive_port_sel.sv
// Scoreboard bench for duato_adaptive_port_sel with directed, hand-computed routes.
module tb_duato_adaptive_port_sel;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  current_x = '0, current_y = '0, dest_x = '0, dest_y = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] credit_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_port;
  logic        out_escape;
  logic [3:0]  out_destport;

  typedef struct {
    string      name;
    logic [4:0] port;
    logic       esc;
    logic [3:0] dp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  duato_adaptive_port_sel #(
    .NX(4), .NY(4), .CRDw(4), .SEL_MODE(0), .STALL_THR(4)
  ) dut (
    .clk(clk), .reset(reset),
    .current_x(current_x), .current_y(current_y),
    .in_valid(in_valid), .dest_x(dest_x), .dest_y(dest_y), .in_ready(in_ready),
    .credit_in(credit_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_port(out_port), .out_escape(out_escape), .out_destport(out_destport)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cred(input int e, input int n, input int w, input int s);
    return {4'(s), 4'(w), 4'(n), 4'(e)};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a header at a negedge, wait (bounded) for in_ready, then let the posedge accept it.
  task automatic applyStimulus(input string name, input int cx, input int cy, input int dx,
                               input int dy, input logic [15:0] cr, input bit push,
                               input logic [4:0] port, input logic esc, input logic [3:0] dp);
    int n = 0;
    exp_t e;
    @(negedge clk);
    current_x = 2'(cx); current_y = 2'(cy);
    dest_x = 2'(dx); dest_y = 2'(dy);
    credit_in = cr;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("[TB] FAIL %s_accept_timeout in_ready=0 expected=1", name);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.name = name; e.port = port; e.esc = esc; e.dp = dp;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: every consumed result is compared with the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_output port=%b expected=none", out_port);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_port"}, 8'(out_port), 8'(e.port));
        checkOutput({e.name, "_escape"}, 8'(out_escape), 8'(e.esc));
        checkOutput({e.name, "_destport"}, 8'(out_destport), 8'(e.dp));
      end
    end
  end

  initial begin
    int n;
    #12;
    checkOutput("rst_valid", 8'(out_valid), 8'd0);
    checkOutput("rst_port", 8'(out_port), 8'd0);
    checkOutput("rst_escape", 8'(out_escape), 8'd0);
    checkOutput("rst_destport", 8'(out_destport), 8'd0);
    checkOutput("rst_in_ready", 8'(in_ready), 8'd1);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus("credit_east", 1, 1, 3, 0, cred(5, 2, 0, 0), 1, 5'b00010, 0, 4'b1111);
    applyStimulus("tie_east",    1, 1, 3, 0, cred(3, 3, 0, 0), 1, 5'b00010, 0, 4'b1111);
    applyStimulus("tie_north",   1, 1, 3, 0, cred(3, 3, 0, 0), 1, 5'b00100, 0, 4'b1111);
    applyStimulus("zero_escape", 1, 1, 3, 0, cred(0, 0, 0, 0), 1, 5'b00010, 1, 4'b1111);
    applyStimulus("local",       2, 2, 2, 2, cred(0, 0, 0, 0), 1, 5'b00001, 0, 4'b0000);
    applyStimulus("credit_south",1, 1, 0, 3, cred(0, 0, 2, 7), 1, 5'b10000, 0, 4'b0011);
    applyStimulus("single_south",1, 1, 1, 3, cred(0, 0, 0, 4), 1, 5'b10000, 0, 4'b0001);
    applyStimulus("single_east", 1, 1, 3, 1, cred(1, 0, 0, 0), 1, 5'b00010, 0, 4'b1010);
    applyStimulus("tie_west",    2, 2, 0, 0, cred(0, 9, 9, 0), 1, 5'b01000, 0, 4'b0111);
    applyStimulus("tie_north2",  2, 2, 0, 0, cred(0, 9, 9, 0), 1, 5'b00100, 0, 4'b0111);
    idle();
    repeat (3) @(negedge clk);

    // Stalled adaptive result: NORTH held four cycles, then forced onto the EAST escape VC.
    @(posedge clk); #1 out_ready = 1'b0;
    applyStimulus("stall", 1, 1, 3, 0, cred(1, 6, 0, 0), 0, 5'b0, 0, 4'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput($sformatf("stall_valid_%0d", i), 8'(out_valid), 8'd1);
      checkOutput($sformatf("stall_north_%0d", i), 8'(out_port), 8'b00100);
      checkOutput($sformatf("stall_in_ready_%0d", i), 8'(in_ready), 8'd0);
    end
    @(negedge clk);
    checkOutput("stall_reroute_port", 8'(out_port), 8'b00010);
    checkOutput("stall_reroute_escape", 8'(out_escape), 8'd1);
    checkOutput("stall_reroute_in_ready", 8'(in_ready), 8'd0);
    begin
      exp_t e;
      e.name = "stall_escape"; e.port = 5'b00010; e.esc = 1'b1; e.dp = 4'b1111;
      sb.push_back(e);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while a result is pending discards it.
    @(posedge clk); #1 out_ready = 1'b0;
    applyStimulus("pending", 1, 1, 3, 0, cred(5, 2, 0, 0), 0, 5'b0, 0, 4'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("pending_valid", 8'(out_valid), 8'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_valid", 8'(out_valid), 8'd0);
    checkOutput("midrst_port", 8'(out_port), 8'd0);
    checkOutput("midrst_escape", 8'(out_escape), 8'd0);
    checkOutput("midrst_destport", 8'(out_destport), 8'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    #1 checkOutput("post_rst_in_ready", 8'(in_ready), 8'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    applyStimulus("post_rst", 1, 1, 3, 1, cred(2, 0, 0, 0), 1, 5'b00010, 0, 4'b1010);
    idle();

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL drain_timeout pending=%0d expected=0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/duato_adaptive_port_sel.md
DUATO_ADAPTIVE_PORT_SEL -- requirements
Module: duato_adaptive_port_sel

Interface
REQ-001 Parameter NX, default 4: mesh columns.
REQ-002 Parameter NY, default 4: mesh rows.
REQ-003 Parameter CRDw, default 4: width of each per-port free-credit count.
REQ-004 Parameter SEL_MODE, default 0: 0 = credit-based selection, 1 = round-robin selection.
REQ-005 Parameter STALL_THR, default 8: consecutive stalled cycles before forced escape re-route; STALL_THR >= 1.
REQ-006 Derived widths: Xw = log2(NX), Yw = log2(NY); each is 1 when its dimension is <= 2.
REQ-007 Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- current_x  in  Xw  this router's x address.
- current_y  in  Yw  this router's y address.
- in_valid  in  1  header presented.
- dest_x  in  Xw  header destination x.
- dest_y  in  Yw  header destination y.
- in_ready  out  1  header accepted when in_valid && in_ready.
- credit_in  in  4*CRDw  free adaptive-VC credits, fields [E,N,W,S] at indices 1..4 minus 1 (E lowest).
- out_valid  out  1  routing result valid.
- out_ready  in  1  downstream consumes the result.
- out_port  out  5  one-hot chosen port: bit0 LOCAL, bit1 EAST, bit2 NORTH, bit3 WEST, bit4 SOUTH.
- out_escape  out  1  result uses the escape VC (deterministic XY).
- out_destport  out  4  candidate-set code {x_plus, y_min, a, b}; a = EAST|WEST candidate, b = NORTH|SOUTH candidate.

Function
REQ-008 Direction: x_plus = dest_x > current_x; x_min = dest_x < current_x; y_plus = dest_y > current_y (SOUTH); y_min = dest_y < current_y (NORTH).
REQ-009 Candidates: same x and y -> {LOCAL}; one axis differs -> that single port; both differ -> one X port and one Y port.
REQ-010 Handshake: in_ready = !out_valid || out_ready; acceptance registers the result; out_valid rises on the next clock edge (latency 1).
REQ-011 out_port, out_escape and out_destport SHALL stay stable while out_valid && !out_ready, except as REQ-015 allows.
REQ-012 Single candidate: out_port is that port and out_escape = 0.
REQ-013 Two candidates with SEL_MODE 0: choose the port with the larger credit sampled in the acceptance cycle. On a tie, choose the X port when the toggle bit is 0 and the Y port when it is 1. The toggle inverts on every tie acceptance.
REQ-014 Two candidates with SEL_MODE 1: choose by toggle alone (0 -> X port); the toggle inverts on every two-candidate acceptance.
REQ-015 Escape:
- Applies when every candidate non-LOCAL port has zero credit at acceptance, or when the stall counter reaches STALL_THR.
- out_port is set to the XY port: the X port if x differs, otherwise the Y port.
- out_escape is set to 1.
- An escape result is never re-routed again.
REQ-016 Stall counter:
- Increments each cycle out_valid && !out_ready && !out_escape.
- Clears on handshake, on escape, or on a new acceptance.
- Saturates at STALL_THR.
REQ-017 Handshake and acceptance in the same cycle load the new result back-to-back, with no bubble.

Reset
REQ-018 While reset is low: out_valid = 0, out_port = 0, out_escape = 0, out_destport = 0, toggle = 0, stall counter = 0. These take effect immediately, asynchronously.
REQ-019 Reset asserted mid-operation discards any pending result; in_ready = 1 on the first cycle after release.

Structure
REQ-020 Shared package noc_routing_pkg SHALL hold:
- port indices LOCAL=0, EAST=1, NORTH=2, WEST=3, SOUTH=4;
- the log2 function;
- the SEL_MODE constants.
REQ-021 The existing mesh_dir SHALL be instantiated as the sole sub-module for direction flags.

Verification (NX=NY=4, STALL_THR=4, SEL_MODE=0 unless stated)
REQ-022 cur(1,1), dest(3,0), credits E=5, N=2 -> one cycle later out_port=5'b00010, out_destport=4'b1111, out_escape=0.
REQ-023 Same route, E=N=3, two back-to-back headers with out_ready=1 -> EAST, then NORTH.
REQ-024 Same route, E=N=0 -> out_port=5'b00010, out_escape=1.
REQ-025 cur(2,2), dest(2,2) -> out_port=5'b00001, out_destport=4'b0000.
REQ-026 Same route, E=1, N=6, out_ready=0 -> NORTH held 4 cycles, then out_port=EAST, out_escape=1; in_ready stays 0 throughout.
REQ-027 Reset pulsed while out_valid=1 -> out_valid=0 within the reset assertion; the next header after release is accepted normally.
